// File: rtl/time_uart_tx.sv
// time_uart_tx: on every change of the seconds field, snapshots the
// calendar/time inputs, converts them to BCD and sends the ASCII line
// "YYYY-MM-DD HH:MM:SS\r\n" over a UART, 8N1, LSB first.
//
// Parameters
//   CLK_HZ     input clock frequency in Hz
//   BAUD       UART bit rate; CPB = CLK_HZ / BAUD clocks per bit
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   en         while high, new frames may start
//   year       14-bit binary year
//   mon, day, hour, min, sec   7-bit binary fields
//   tx         UART serial output, idle high
//   busy       high from CONVERT entry until IDLE is re-entered
//   frame_done one-cycle pulse on the cycle busy falls
module time_uart_tx #(
    parameter int CLK_HZ = 125000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [13:0] year,
    input  logic [6:0]  mon,
    input  logic [6:0]  day,
    input  logic [6:0]  hour,
    input  logic [6:0]  min,
    input  logic [6:0]  sec,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);
    localparam int CPB       = CLK_HZ / BAUD;
    localparam int BW        = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int CONV_LAST = 13;  // 14 shift-add-3 steps
    localparam int LAST_CHAR = 20;  // 21 characters per frame
    localparam logic [7:0] STAR = 8'h2A;

    typedef enum logic [2:0] {IDLE, CONVERT, START, DATA, STOP, NEXT} state_t;

    state_t          state, state_nx;
    logic [6:0]      prev_sec;
    logic            prev_valid;
    logic            pending;
    logic [3:0]      conv_cnt;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [4:0]      char_idx;
    // Field order in both arrays: 0 year, 1 mon, 2 day, 3 hour, 4 min, 5 sec.
    logic [5:0][13:0] snap;  // binary snapshot, frozen for the whole frame
    logic [5:0][29:0] conv;  // {bcd[15:0], bin[13:0]} double-dabble working regs
    logic [5:0]      ovf;
    logic [7:0]      cur_char;
    logic            trigger;
    logic            start_frame;
    logic            baud_end;

    // One shift-add-3 iteration over four BCD digits sitting above the binary part.
    function automatic logic [29:0] dabble_step(input logic [29:0] x);
        logic [29:0] y;
        y = x;
        for (int d = 0; d < 4; d++) begin
            if (y[14+4*d +: 4] >= 4'd5)
                y[14+4*d +: 4] = y[14+4*d +: 4] + 4'd3;
        end
        return {y[28:0], 1'b0};
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 | {4'h0, d};
    endfunction

    assign trigger     = prev_valid && (sec != prev_sec);
    // A pending request wins over a same-cycle trigger; the trigger is absorbed.
    assign start_frame = (state == IDLE) && en && (pending || trigger);
    assign baud_end    = (baud_cnt == BW'(CPB - 1));
    assign busy        = (state != IDLE);

    assign ovf[0] = (snap[0] > 14'd9999);
    always_comb begin
        for (int i = 1; i < 6; i++) ovf[i] = (snap[i] > 14'd99);
    end

    // Character ROM: BCD digit d of a field lives at conv[f][14+4*d +: 4].
    always_comb begin
        cur_char = 8'h20;
        case (char_idx)
            5'd0:  cur_char = ovf[0] ? STAR : ascii_digit(conv[0][29:26]);
            5'd1:  cur_char = ovf[0] ? STAR : ascii_digit(conv[0][25:22]);
            5'd2:  cur_char = ovf[0] ? STAR : ascii_digit(conv[0][21:18]);
            5'd3:  cur_char = ovf[0] ? STAR : ascii_digit(conv[0][17:14]);
            5'd4:  cur_char = 8'h2D;
            5'd5:  cur_char = ovf[1] ? STAR : ascii_digit(conv[1][21:18]);
            5'd6:  cur_char = ovf[1] ? STAR : ascii_digit(conv[1][17:14]);
            5'd7:  cur_char = 8'h2D;
            5'd8:  cur_char = ovf[2] ? STAR : ascii_digit(conv[2][21:18]);
            5'd9:  cur_char = ovf[2] ? STAR : ascii_digit(conv[2][17:14]);
            5'd10: cur_char = 8'h20;
            5'd11: cur_char = ovf[3] ? STAR : ascii_digit(conv[3][21:18]);
            5'd12: cur_char = ovf[3] ? STAR : ascii_digit(conv[3][17:14]);
            5'd13: cur_char = 8'h3A;
            5'd14: cur_char = ovf[4] ? STAR : ascii_digit(conv[4][21:18]);
            5'd15: cur_char = ovf[4] ? STAR : ascii_digit(conv[4][17:14]);
            5'd16: cur_char = 8'h3A;
            5'd17: cur_char = ovf[5] ? STAR : ascii_digit(conv[5][21:18]);
            5'd18: cur_char = ovf[5] ? STAR : ascii_digit(conv[5][17:14]);
            5'd19: cur_char = 8'h0D;
            5'd20: cur_char = 8'h0A;
            default: cur_char = 8'h20;
        endcase
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        tx       = 1'b1;
        case (state)
            IDLE:    if (start_frame) state_nx = CONVERT;
            CONVERT: if (conv_cnt == 4'(CONV_LAST)) state_nx = START;
            START: begin
                tx = 1'b0;
                if (baud_end) state_nx = DATA;
            end
            DATA: begin
                tx = cur_char[bit_cnt];
                if (baud_end && bit_cnt == 3'd7) state_nx = STOP;
            end
            STOP:    if (baud_end) state_nx = NEXT;
            NEXT:    state_nx = (char_idx == 5'(LAST_CHAR)) ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: prev_sec is a plain pipeline register and is deliberately left out
    // of reset; prev_valid alone decides whether its value is trusted.
    always_ff @(posedge clk) begin
        prev_sec <= sec;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the pre-edge value of every other.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            prev_valid <= 1'b0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            conv_cnt   <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            char_idx   <= '0;
            snap       <= '0;
            conv       <= '0;
        end else begin
            state      <= state_nx;
            prev_valid <= 1'b1;
            frame_done <= (state == NEXT) && (char_idx == 5'(LAST_CHAR));

            // Single-depth request: extra triggers merge; en=0 in IDLE drops them.
            if (start_frame)
                pending <= 1'b0;
            else if (trigger && (busy || pending))
                pending <= 1'b1;

            if (start_frame) begin
                snap[0]  <= year;
                snap[1]  <= {7'd0, mon};
                snap[2]  <= {7'd0, day};
                snap[3]  <= {7'd0, hour};
                snap[4]  <= {7'd0, min};
                snap[5]  <= {7'd0, sec};
                conv[0]  <= {16'd0, year};
                conv[1]  <= {23'd0, mon};
                conv[2]  <= {23'd0, day};
                conv[3]  <= {23'd0, hour};
                conv[4]  <= {23'd0, min};
                conv[5]  <= {23'd0, sec};
                conv_cnt <= '0;
            end else if (state == CONVERT) begin
                for (int i = 0; i < 6; i++) conv[i] <= dabble_step(conv[i]);
                conv_cnt <= (conv_cnt == 4'(CONV_LAST)) ? 4'd0 : conv_cnt + 4'd1;
            end

            if (state == START || state == DATA || state == STOP)
                baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            else
                baud_cnt <= '0;

            if (state == DATA && baud_end)
                bit_cnt <= bit_cnt + 3'd1;  // 7 wraps to 0 naturally

            if (state == NEXT)
                char_idx <= (char_idx == 5'(LAST_CHAR)) ? 5'd0 : char_idx + 5'd1;
        end
    end

endmodule

// File: doc/time_uart_tx.md
TIME_UART_TX -- requirements
Module: time_uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 125000000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the UART bit rate; CPB = CLK_HZ/BAUD (integer division) clocks per bit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: while high, new frames are allowed to start.
REQ-006 The block SHALL have port year, input, 14 bits: binary year from the calendar counter.
REQ-007 The block SHALL have ports mon, day, hour, min and sec, each input, 7 bits: binary calendar and time fields.
REQ-008 The block SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high from frame start until the last stop bit ends.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after the final stop bit.

Function
REQ-011 The block SHALL register sec every cycle into prev_sec; a trigger exists when sec != prev_sec and prev_valid=1.
REQ-012 The block SHALL set prev_valid on the first cycle after reset release without raising a trigger, so no frame is sent on reset.
REQ-013 A trigger in IDLE with en=1 SHALL capture all six fields into snapshot registers on that cycle and enter CONVERT.
REQ-014 A trigger while busy=1, or while pending=1 in IDLE, SHALL set pending; pending is single-depth, and further triggers are merged into it.
REQ-015 A trigger with en=0 in IDLE SHALL be dropped and SHALL NOT set pending.
REQ-016 In IDLE with pending=1 and en=1, the block SHALL clear pending, capture the current inputs and enter CONVERT; this SHALL take priority over a same-cycle trigger, which is absorbed.
REQ-017 In IDLE with pending=1 and en=0, pending SHALL hold until en rises.
REQ-018 The state machine SHALL have states IDLE, CONVERT, START, DATA, STOP and NEXT.
REQ-019 CONVERT SHALL last exactly 14 cycles, running parallel shift-add-3 BCD conversion of all snapshot fields (7-bit fields zero-extended).
REQ-020 CONVERT SHALL then go to START for character 0.
REQ-021 The frame SHALL be 21 ASCII characters, "YYYY-MM-DD HH:MM:SS" followed by 0x0D 0x0A, with leading zeros kept.
REQ-022 Range rule: a year above 9999 SHALL send "****"; any 2-digit field above 99 SHALL send "**". Calendar validity is not checked.
REQ-023 Each character SHALL be sent 8N1 on tx: START is tx=0 for CPB cycles, DATA is 8 bits LSB first at CPB cycles each, STOP is tx=1 for CPB cycles.
REQ-024 NEXT SHALL last 1 cycle with tx=1, then go to START for the next character or, after character 20, to IDLE.
REQ-025 busy SHALL rise on the cycle CONVERT is entered and fall on the cycle IDLE is re-entered.
REQ-026 frame_done SHALL pulse on the same cycle busy falls.
REQ-027 Frame length from CONVERT entry to IDLE SHALL be 14 + 21*(10*CPB+1) cycles.
REQ-028 Snapshot registers SHALL NOT change during a frame, even if the inputs change.
REQ-029 en falling mid-frame SHALL NOT abort the frame.
REQ-030 The bit counter (0..7), char index (0..20) and baud counter (0..CPB-1) SHALL wrap only at their terminal counts.

Reset
REQ-031 While rst=0 at a clock edge, the block SHALL force state=IDLE, tx=1, busy=0, frame_done=0, pending=0, prev_valid=0, all counters to 0 and snapshot to 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame on that edge with tx=1 from that edge, and no frame_done SHALL pulse.

Verification
REQ-033 The bench SHALL use CLK_HZ=16 and BAUD=1 (CPB=16), apply reset with sec=0, release reset and hold the inputs for 100 cycles; required response: tx=1 and busy=0 throughout.
REQ-034 The bench SHALL set year=2024, mon=1, day=31, hour=23, min=59 and step sec 0->55; required response: busy rises next cycle, the first start bit appears 14 cycles later, the decoded bytes are "2024-01-31 23:59:55\r\n", and frame_done pulses after 14+21*161=3395 cycles.
REQ-035 The bench SHALL change sec 3 times mid-frame, ending at 57; required response: exactly one follow-up frame starts 1 cycle after frame_done, reading ":57".
REQ-036 The bench SHALL apply year=12000 and hour=120; required response: the frame contains "****" and "**" in those positions.
REQ-037 The bench SHALL hold en=0 and change sec; required response: no frame is sent. It SHALL then set en=1 with no change; required response: still no frame is sent.
REQ-038 The bench SHALL assert rst=0 during character 5; required response: tx=1 on the next edge, busy=0, no frame_done, and no frame after release until the next sec change.
